// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
package serial_sub_ctrl_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_t;

endpackage

// File: rtl/serial_sub_ctrl_subtractor1b.sv
// 1-bit full-subtractor cell: Difference = A - B - Bin, Bout set when that underflows.
module Subtractor1b (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Difference,
  output logic Bout
);

  assign Difference = A ^ B ^ Bin;
  assign Bout       = (~A & B) | (~A & Bin) | (B & Bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one shared 1-bit cell sequenced LSB first over WIDTH cycles.
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] diff_r;
  logic [CNT_W-1:0] cnt_r;
  logic             borrow_r;
  logic             ready_r;
  logic             busy_r;
  logic             done_r;
  logic             bout_r;
  logic             ovf_r;
  logic             cell_diff_s;
  logic             cell_bout_s;

  Subtractor1b u_cell (
    .A          (a_sh_r[0]),
    .B          (b_sh_r[0]),
    .Bin        (borrow_r),
    .Difference (cell_diff_s),
    .Bout       (cell_bout_s)
  );

  // Sequencer: FSM, operand shift registers, borrow chain and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      diff_r   <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      borrow_r <= 1'b0;
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      bout_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && ready_r) begin
            a_sh_r   <= a;
            b_sh_r   <= b;
            borrow_r <= bin;
            cnt_r    <= {CNT_W{1'b0}};
            diff_r   <= {WIDTH{1'b0}};
            bout_r   <= 1'b0;
            ovf_r    <= 1'b0;
            ready_r  <= 1'b0;
            busy_r   <= 1'b1;
            state_r  <= ST_RUN;
          end
        end
        ST_RUN: begin
          diff_r   <= {cell_diff_s, diff_r[WIDTH-1:1]};
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          borrow_r <= cell_bout_s;
          cnt_r    <= cnt_r + CNT_ONE;
          // MSB cycle: borrow_r is the borrow into the sign bit, so overflow is it XOR the final borrow
          if (cnt_r == CNT_LAST) begin
            bout_r  <= cell_bout_s;
            ovf_r   <= borrow_r ^ cell_bout_s;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready = ready_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign diff  = diff_r;
  assign bout  = bout_r;
  assign ovf   = ovf_r;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench: table vectors plus scoreboards for an 8-bit and a 4-bit instance.
module tb_serial_sub_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // 8-bit instance
  logic       start8, bin8, ready8, busy8, done8, bout8, ovf8;
  logic [7:0] a8, b8, diff8;
  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .ready(ready8), .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  // 4-bit instance
  logic       start4, bin4, ready4, busy4, done4, bout4, ovf4;
  logic [3:0] a4, b4, diff4;
  serial_sub_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .ready(ready4), .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4)
  );

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    int         acc;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } vec_t;

  exp_t q8[$];
  exp_t q4[$];
  int   done8_cnt = 0, exp8_cnt = 0;
  int   done4_cnt = 0, exp4_cnt = 0;
  bit   chk_ready8 = 1'b0;

  // Scoreboard for the 8-bit instance; latency counts cycles after the accept edge (first = 1)
  always @(negedge clk) begin : mon8
    exp_t e;
    if (chk_ready8) begin
      chk("ready_after_done8", 32'(ready8), 32'd1);
      chk_ready8 = 1'b0;
    end
    if (done8 === 1'b1) begin
      done8_cnt++;
      if (q8.size() == 0) begin
        chk("spurious_done8", 32'(done8), 32'd0);
      end else begin
        e = q8.pop_front();
        chk("diff8", 32'(diff8), 32'(e.diff));
        chk("bout8", 32'(bout8), 32'(e.bout));
        chk("ovf8", 32'(ovf8), 32'(e.ovf));
        chk("latency8", 32'(cyc - e.acc + 1), 32'd9);
        chk_ready8 = 1'b1;
      end
    end
  end

  // Scoreboard for the 4-bit instance
  always @(negedge clk) begin : mon4
    exp_t e;
    if (done4 === 1'b1) begin
      done4_cnt++;
      if (q4.size() == 0) begin
        chk("spurious_done4", 32'(done4), 32'd0);
      end else begin
        e = q4.pop_front();
        chk("diff4", 32'(diff4), 32'(e.diff[3:0]));
        chk("bout4", 32'(bout4), 32'(e.bout));
        chk("ovf4", 32'(ovf4), 32'(e.ovf));
        chk("latency4", 32'(cyc - e.acc + 1), 32'd5);
      end
    end
  end

  task automatic wait_ready8();
    int n = 0;
    @(negedge clk);
    while (ready8 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ready8 !== 1'b1) chk("ready_timeout8", 32'(ready8), 32'd1);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [7:0] d, input logic bo, input logic ov, input bit track);
    exp_t e;
    wait_ready8();
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    @(posedge clk); #1;
    if (track) begin
      e.diff = d; e.bout = bo; e.ovf = ov; e.acc = cyc;
      q8.push_back(e);
      exp8_cnt++;
    end
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom_range(0, 1));
    chk("busy_run8", 32'(busy8), 32'd1);
    chk("ready_run8", 32'(ready8), 32'd0);
  endtask

  task automatic drain8();
    int n = 0;
    while (q8.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain8", 32'(q8.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin);
    exp_t e;
    int   n = 0;
    int   s;
    logic [4:0] full;
    @(negedge clk);
    while (ready4 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (ready4 !== 1'b1) chk("ready_timeout4", 32'(ready4), 32'd1);
    a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
    full = {1'b0, a} - {1'b0, b} - {4'd0, bin};
    s = int'($signed(a)) - int'($signed(b)) - int'(bin);
    @(posedge clk); #1;
    e.diff = {4'd0, full[3:0]};
    e.bout = full[4];
    e.ovf  = (s < -8) || (s > 7);
    e.acc  = cyc;
    q4.push_back(e);
    exp4_cnt++;
    @(negedge clk);
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   acc;
    exp_t e;
    int   n;

    vecs[0] = '{a: 8'h5A, b: 8'h23, bin: 1'b0, diff: 8'h37, bout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 8'h10, b: 8'h20, bin: 1'b1, diff: 8'hEF, bout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 8'h80, b: 8'h01, bin: 1'b0, diff: 8'h7F, bout: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 8'h7F, b: 8'hFF, bin: 1'b0, diff: 8'h80, bout: 1'b1, ovf: 1'b1};
    vecs[4] = '{a: 8'h00, b: 8'h00, bin: 1'b1, diff: 8'hFF, bout: 1'b1, ovf: 1'b0};

    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
    start4 = 1'b0; a4 = 4'h0;  b4 = 4'h0;  bin4 = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready8), 32'd1);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_diff", 32'(diff8), 32'd0);
    chk("rst_bout", 32'(bout8), 32'd0);
    chk("rst_ovf", 32'(ovf8), 32'd0);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 5; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout, vecs[i].ovf, 1'b1);
      drain8();
    end

    // Start pulsed during RUN must be ignored
    op8(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    drain8();
    repeat (12) @(negedge clk);
    chk("ignored_start_done_count", 32'(done8_cnt), 32'(exp8_cnt));

    // Start held high: accepts every 10 cycles
    wait_ready8();
    a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    for (int k = 0; k < 3; k++) begin
      e.diff = 8'h7F; e.bout = 1'b0; e.ovf = 1'b1; e.acc = acc + 10 * k;
      q8.push_back(e);
      exp8_cnt++;
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (q8.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("held_drain8", 32'(q8.size()), 32'd0);
    repeat (12) @(negedge clk);
    chk("held_done_count", 32'(done8_cnt), 32'(exp8_cnt));

    // Reset in the middle of RUN discards the operation
    op8(8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy8), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", 32'(ready8), 32'd1);
    chk("midrst_busy", 32'(busy8), 32'd0);
    chk("midrst_diff", 32'(diff8), 32'd0);
    chk("midrst_done", 32'(done8), 32'd0);
    repeat (15) @(negedge clk);
    chk("midrst_done_count", 32'(done8_cnt), 32'(exp8_cnt));
    op8(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0, 1'b1);
    drain8();

    // Exhaustive 4-bit sweep against the arithmetic model
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++)
          op4(4'(ai), 4'(bi), 1'(ci));
    n = 0;
    while (q4.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain4", 32'(q4.size()), 32'd0);
    repeat (3) @(negedge clk);
    chk("done4_count", 32'(done4_cnt), 32'(exp4_cnt));
    chk("done8_count", 32'(done8_cnt), 32'(exp8_cnt));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
